// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, requester identifiers and the legal-opcode decode.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1111;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL,
      OP_SRL, OP_SRA, OP_XOR, OP_SLT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry registered response slot: loads on grant, clears when drained, holds otherwise.
module alu_rsp_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              drain_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              zero_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              err_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              err_o
);

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q,   zero_d;
  logic [TAG_W-1:0]  tag_q,    tag_d;
  logic              err_q,    err_d;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    tag_d    = tag_q;
    err_d    = err_q;
    // A load in the same cycle as a drain wins: the slot stays full with the new data.
    if (load_i) begin
      valid_d  = 1'b1;
      result_d = result_i;
      zero_d   = zero_i;
      tag_d    = tag_i;
      err_d    = err_i;
    end else if (drain_i) begin
      valid_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload is reset as well as valid, because requesters may observe it after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign tag_o    = tag_q;
  assign err_o    = err_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the EX stage and the auxiliary unit.
// Optional illegal-opcode flagging is built when ALU_OP_CHECK_EN is defined.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp0_err,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [TAG_W-1:0]  rsp1_tag,
  output logic              rsp1_err,

  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  req_id_e           rr_last_q, rr_last_d;
  logic              elig0, elig1;
  logic              grant0, grant1;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] cap_result;
  logic              cap_err;

  always_comb begin
    elig0      = 1'b0;
    elig1      = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rr_last_d  = rr_last_q;
    alu_op     = OP_AND;
    alu_a      = '0;
    alu_b      = '0;
    grant_tag  = '0;
    cap_result = alu_result;
    cap_err    = 1'b0;

    // A slot draining this cycle counts as free; no grants while reset is held.
    elig0 = rst_n && req0_valid && (!rsp0_valid || rsp0_ready);
    elig1 = rst_n && req1_valid && (!rsp1_valid || rsp1_ready);

    if (elig0 && elig1) begin
      grant0 = (rr_last_q == REQ_AUX);
      grant1 = (rr_last_q == REQ_EX);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end

    if (grant0) begin
      rr_last_d = REQ_EX;
      alu_op    = req0_op;
      alu_a     = req0_a;
      alu_b     = req0_b;
      grant_tag = req0_tag;
    end else if (grant1) begin
      rr_last_d = REQ_AUX;
      alu_op    = req1_op;
      alu_a     = req1_a;
      alu_b     = req1_b;
      grant_tag = req1_tag;
    end

`ifdef ALU_OP_CHECK_EN
    // Illegal opcodes still complete, but with a zeroed result and the error flag set.
    if (!is_legal_op(alu_op)) begin
      cap_result = '0;
      cap_err    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_q <= REQ_AUX;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  alu_rsp_slot #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (grant0),
    .drain_i  (rsp0_ready),
    .result_i (cap_result),
    .zero_i   (alu_zero),
    .tag_i    (grant_tag),
    .err_i    (cap_err),
    .valid_o  (rsp0_valid),
    .result_o (rsp0_result),
    .zero_o   (rsp0_zero),
    .tag_o    (rsp0_tag),
    .err_o    (rsp0_err)
  );

  alu_rsp_slot #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (grant1),
    .drain_i  (rsp1_ready),
    .result_i (cap_result),
    .zero_i   (alu_zero),
    .tag_i    (grant_tag),
    .err_i    (cap_err),
    .valid_o  (rsp1_valid),
    .result_o (rsp1_result),
    .zero_o   (rsp1_zero),
    .tag_o    (rsp1_tag),
    .err_o    (rsp1_err)
  );

endmodule
